truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
- Sequencer that drives a 4-input combinational function unit through all 16 input vectors, in order a,b,c,d with a as MSB.
- Samples the unit's output after a programmable settle dwell, builds a 16-bit truth table and counts the ones.
- Compares the table against a golden table and reports pass/fail with a start/done handshake.
- Sits beside the function unit as its self-test/characterisation controller.

Parameters:
- DWELL, default 2: clock cycles each vector is held before sampling, including the sample cycle. Legal range 1..255.
- DW_W, default 8: width of the dwell counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a sweep when sampled high in IDLE.
- abort  in  1  synchronous cancel of a sweep in progress.
- golden  in  16  expected truth table, bit i = expected F for vector i. Sampled at start.
- f_in  in  1  output of the function unit under test.
- abcd_out  out  4  vector to the unit: [3]=a, [2]=b, [1]=c, [0]=d.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse when a sweep completes.
- table_out  out  16  captured truth table.
- ones_count  out  5  number of 1s in table_out, range 0..16.
- valid  out  1  table_out, ones_count and pass describe a complete sweep.
- pass  out  1  table_out == golden latched; qualified by valid.

Behaviour:
- Reset (async, rst_n=0), all registers zero:
  - state=IDLE, abcd_out=0, busy=0, done=0, valid=0, pass=0.
  - table_out=0, ones_count=0, idx=0, dwell counter=0.
- States: IDLE, SETTLE, DONE.
- IDLE, start=1 and abort=0:
  - Latch golden.
  - Clear table_out, ones_count, valid, pass.
  - idx=0, dwell=0, go to SETTLE.
- SETTLE:
  - abcd_out=idx throughout.
  - dwell increments each cycle.
  - On the cycle where dwell==DWELL-1:
    - table_out[idx] <= f_in.
    - ones_count += f_in.
    - If idx==15, go to DONE; otherwise idx++ and dwell=0.
- DONE, lasts one cycle:
  - done=1.
  - valid<=1.
  - pass <= (final table == latched golden). The comparison includes the bit 15 sample written on the entering edge.
  - Return to IDLE.
- Latency: start accepted at edge T → done high in cycle T+16*DWELL+1. With DWELL=2, done is high 33 cycles after start.
- idx wrap: idx never wraps. The sweep ends at 15, and abcd_out holds 15 through DONE and IDLE until the next start.
- start while busy: ignored, with no restart.
- abort:
  - In SETTLE or DONE: next state is IDLE. valid=0, pass=0, done is not pulsed. table_out holds partial contents.
  - Same cycle as start in IDLE: abort wins and no sweep starts.
- Reset mid-sweep: immediate return to the reset values above.
- Results stay stable in IDLE until the next accepted start.
- f_in is assumed to settle within DWELL-1 cycles. The block does not synchronise f_in.

Decomposition:
- Package tts_pkg holds:
  - state enum (IDLE, SETTLE, DONE).
  - NUM_VEC=16, IDX_W=4, CNT_W=5.
- Sub-module tts_dwell_timer: DWELL-parameterised counter with clear and enable inputs and a terminal-count output.
- Top-level contents: FSM, idx, table/count, compare.
- The function unit is instantiated alongside the sweeper by the integrating level or bench, not inside the sweeper.

Test Plan:
- Nominal run:
  - Stimulus: reset, DWELL=2, golden=16'hFF0D, unit F=a|~b&~d|~b&c, start pulse.
  - Required: abcd_out steps 0..15 at two cycles each; table_out=16'hFF0D; ones_count=11; done pulse 33 cycles after start; pass=1, valid=1.
- Golden mismatch:
  - Stimulus: same unit, golden=16'hFF0F.
  - Required: table_out=16'hFF0D, valid=1, pass=0.
- Abort mid-sweep:
  - Stimulus: abort at idx=6.
  - Required: next cycle busy=0; no done pulse; valid=0; table_out bits 5..0 = 6'b001101 and bits 15..6 = 0.
- Input priority:
  - Stimulus: start during busy, then start+abort together in IDLE.
  - Required: the first start has no effect and the sweep completes normally; the second leaves busy=0.
- Async reset mid-sweep:
  - Stimulus: rst_n low at idx=9, without waiting for a clock edge.
  - Required: all outputs zero immediately; a fresh start then completes normally.
- Boundary dwell and extreme tables:
  - Stimulus: DWELL=1, f_in tied 1, golden=16'hFFFF; repeat with f_in tied 0.
  - Required: done 17 cycles after start; ones_count=16 then 0; table_out=16'hFFFF then 16'h0000; pass=1 for the first run, pass=0 for the second.

Source files
------------

// File: rtl/tts_pkg.sv
// Shared types and sizes for the truth-table sweeper.
// Vector count and counter widths are fixed by the 4-input function unit.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int NUM_VEC = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 5;

endpackage

// File: rtl/tts_dwell_timer.sv
// Up-counting dwell timer; o_tc flags the sample cycle (count == DWELL-1).
// Clear has priority over enable.
module tts_dwell_timer #(
  parameter int DWELL = 2,
  parameter int DW_W  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  logic [DW_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == DW_W'(DWELL - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Self-test sequencer: walks a 4-input function unit through all 16 vectors,
// captures its truth table, counts ones and compares against a golden table.
import tts_pkg::*;

// state  | meaning
// IDLE   | waiting for start; results from the last sweep held stable
// SETTLE | vector idx applied, dwell counting toward the sample cycle
// DONE   | one-cycle completion: done pulse, valid/pass latched
module truth_table_sweeper #(
  parameter int DWELL = 2,
  parameter int DW_W  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] golden,
  input  logic        f_in,
  output logic [3:0]  abcd_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  ones_count,
  output logic        valid,
  output logic        pass
);

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_VEC-1:0] r_golden;
  logic [NUM_VEC-1:0] r_table;
  logic [CNT_W-1:0]   r_ones;
  logic               r_valid;
  logic               r_pass;

  logic w_tc;
  logic w_accept;
  logic w_sample;
  logic w_last;

  assign w_accept = (r_state == IDLE) && start && !abort;
  assign w_sample = (r_state == SETTLE) && w_tc && !abort;
  assign w_last   = (r_idx == IDX_W'(NUM_VEC - 1));

  tts_dwell_timer #(
    .DWELL (DWELL),
    .DW_W  (DW_W)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_accept || w_sample),
    .i_enable (r_state == SETTLE),
    .o_tc     (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (abort) begin
          w_next = IDLE;
        end else if (w_tc && w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        busy   = 1'b1;
        done   = !abort;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // idx is not advanced past the last vector, so abcd_out parks at 15 after a sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_golden <= '0;
      r_table  <= '0;
      r_ones   <= '0;
      r_valid  <= 1'b0;
      r_pass   <= 1'b0;
    end else if (w_accept) begin
      r_idx    <= '0;
      r_golden <= golden;
      r_table  <= '0;
      r_ones   <= '0;
      r_valid  <= 1'b0;
      r_pass   <= 1'b0;
    end else if (abort && (r_state != IDLE)) begin
      r_valid <= 1'b0;
      r_pass  <= 1'b0;
    end else if (w_sample) begin
      r_table[r_idx] <= f_in;
      r_ones         <= r_ones + CNT_W'(f_in);
      if (!w_last) r_idx <= r_idx + 1'b1;
    end else if (r_state == DONE) begin
      r_valid <= 1'b1;
      r_pass  <= (r_table == r_golden);
    end
  end

  assign abcd_out   = r_idx;
  assign table_out  = r_table;
  assign ones_count = r_ones;
  assign valid      = r_valid;
  assign pass       = r_pass;

endmodule
